// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_ctrl
// Purpose  : Bit-serial ALU controller for ADD/SUB/MUL/AND/OR/XOR, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             op_err
);

  localparam int             c_cw     = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
  localparam logic [2:0]     c_op_add = 3'd0;
  localparam logic [2:0]     c_op_sub = 3'd1;
  localparam logic [2:0]     c_op_mul = 3'd2;
  localparam logic [2:0]     c_op_and = 3'd3;
  localparam logic [2:0]     c_op_or  = 3'd4;
  localparam logic [2:0]     c_op_xor = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [c_cw-1:0]  r_k;
  logic [c_cw-1:0]  r_j;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic             r_carry_out;
  logic             r_op_err;

  logic            w_valid;
  logic            w_last_bit;
  logic            w_last_pass;
  logic [c_cw-1:0] w_idx;
  logic            w_x;
  logic            w_y;
  logic            w_sum;
  logic            w_cout;
  logic            w_rbit;

  assign w_valid     = (r_op <= c_op_xor);
  assign w_last_bit  = (r_k == c_last);
  assign w_last_pass = (r_j == c_last);
  assign w_idx       = r_k - r_j;

  // Full-adder operands: MUL adds the shifted partial-product bit into the
  // accumulator bit that is currently rotated into position 0.
  always_comb begin
    w_x    = r_a[r_k];
    w_y    = r_b[r_k];
    w_rbit = 1'b0;
    case (r_op)
      c_op_sub: w_y = ~r_b[r_k];
      c_op_mul: begin
        w_x = r_res[0];
        w_y = (r_k >= r_j) ? (r_a[w_idx] & r_b[r_j]) : 1'b0;
      end
      default: ;
    endcase
    w_sum  = w_x ^ w_y ^ r_c;
    w_cout = (w_x & w_y) | (r_c & (w_x ^ w_y));
    case (r_op)
      c_op_and: w_rbit = r_a[r_k] & r_b[r_k];
      c_op_or:  w_rbit = r_a[r_k] | r_b[r_k];
      c_op_xor: w_rbit = r_a[r_k] ^ r_b[r_k];
      default:  w_rbit = w_sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Invalid ops still spend one cycle in RUN so done lands one cycle after acceptance.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_RUN;
      S_RUN: begin
        if (!w_valid)
          w_next_state = S_DONE;
        else if (w_last_bit && ((r_op != c_op_mul) || w_last_pass))
          w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_k         <= '0;
      r_j         <= '0;
      r_c         <= 1'b0;
      r_res       <= '0;
      r_carry_out <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a         <= a;
            r_b         <= b;
            r_op        <= op;
            r_k         <= '0;
            r_j         <= '0;
            r_c         <= (op == c_op_sub);
            r_res       <= '0;
            r_carry_out <= 1'b0;
            r_op_err    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_valid) begin
            r_op_err <= 1'b1;
          end else begin
            r_res <= {w_rbit, r_res[WIDTH-1:1]};
            r_c   <= w_cout;
            if (w_last_bit) begin
              r_k <= '0;
              r_j <= r_j + 1'b1;
              if (r_op == c_op_mul)
                r_c <= 1'b0;
              else
                r_carry_out <= ((r_op == c_op_add) || (r_op == c_op_sub)) ? w_cout : 1'b0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_res;
  assign carry_out = r_carry_out;
  assign op_err    = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_ctrl
// Purpose  : Directed and randomized checks of alu_serial_ctrl against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       op_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .op_err   (op_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic and the documented latencies.
  task automatic ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] r, output logic co, output logic err, output int lat);
    int p;
    r = 8'h00; co = 1'b0; err = 1'b0; lat = 8;
    case (o)
      3'd0: begin p = int'(x) + int'(y); r = p[7:0]; co = p[8]; end
      3'd1: begin p = int'(x) - int'(y); r = p[7:0]; co = (x >= y); end
      3'd2: begin p = int'(x) * int'(y); r = p[7:0]; lat = 64; end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      default: begin err = 1'b1; lat = 1; end
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input bit inject, input string nm);
    logic [7:0] er;
    logic       eco;
    logic       eerr;
    int         elat;
    int         cyc;
    int         nbusy;
    ref_op(o, x, y, er, eco, eerr, elat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    nbusy = busy ? 1 : 0;
    cyc   = 0;
    while (!done && cyc < 200) begin
      if (inject && cyc == 3) begin
        start = 1'b1; op = 3'($urandom_range(0, 5)); a = 8'($urandom); b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    chk({nm, " latency"}, cyc, elat);
    chk({nm, " result"}, result, er);
    chk({nm, " carry_out"}, carry_out, eco);
    chk({nm, " op_err"}, op_err, eerr);
    chk({nm, " busy cycles"}, nbusy, elat + 1);
    @(posedge clk); #1;
    chk({nm, " done pulse width"}, done, 1'b0);
    chk({nm, " busy after done"}, busy, 1'b0);
    chk({nm, " result held"}, result, er);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 8'h00);
    chk("reset carry_out", carry_out, 1'b0);
    chk("reset op_err", op_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 8'hB5, 8'h6E, 1'b0, "add b5+6e");
    run_op(3'd1, 8'h10, 8'h20, 1'b0, "sub 10-20");
    run_op(3'd1, 8'h20, 8'h10, 1'b0, "sub 20-10");
    run_op(3'd2, 8'h0D, 8'h0B, 1'b0, "mul 0d*0b");
    run_op(3'd2, 8'h20, 8'h10, 1'b0, "mul 20*10");
    run_op(3'd3, 8'hCA, 8'h5C, 1'b0, "and");
    run_op(3'd4, 8'hCA, 8'h5C, 1'b0, "or");
    run_op(3'd5, 8'hCA, 8'h5C, 1'b0, "xor");
    run_op(3'd6, 8'h12, 8'h34, 1'b0, "invalid 110");
    run_op(3'd0, 8'h3C, 8'h4D, 1'b1, "add with ignored start");
    run_op(3'd1, 8'h55, 8'h55, 1'b0, "sub equal");
    run_op(3'd0, 8'hFF, 8'h01, 1'b0, "add wrap");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 8'hE7; b = 8'hB3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 8'h00);
    chk("abort carry_out", carry_out, 1'b0);
    chk("abort op_err", op_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 8'h01, 8'h01, 1'b0, "add after reset");

    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
